// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch front end with stall, flush redirect and two-slot kill
module pc_fetch_unit #(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic [PC_WIDTH-1:0]   imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [PC_WIDTH-1:0]   current_pc_o,
    output logic [DATA_WIDTH-1:0] instruction_o,
    output logic                  valid_o,
    output logic                  misalign_o,
    output logic [31:0]           fetch_cnt_o
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d1;
    logic [1:0]          kill_cnt;
    logic                boot;
    logic [31:0]         fetch_cnt;
    logic                misalign;

    logic                flush_eff;
    logic                masked;

    // Output pair: rdata always belongs to pc_d1; boot, a live redirect or an open kill window blank the slot
    always_comb begin
        flush_eff     = flush & ~stall;
        masked        = boot | flush_eff | (kill_cnt != 2'd0);
        imem_addr_o   = pc_q;
        current_pc_o  = pc_d1;
        valid_o       = ~masked;
        instruction_o = masked ? NOP_INST : imem_rdata_i;
        misalign_o    = misalign;
        fetch_cnt_o   = fetch_cnt;
    end

    // PC sequencing and kill window: stall beats flush, flush beats sequential +4
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            pc_d1     <= RESET_PC;
            kill_cnt  <= 2'd0;
            boot      <= 1'b1;
            fetch_cnt <= 32'd0;
            misalign  <= 1'b0;
        end else begin
            pc_d1    <= pc_q;
            boot     <= 1'b0;
            misalign <= flush_eff && (redirect_pc_i[1:0] != 2'b00);
            if (!masked && !stall) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (!stall) begin
                if (flush_eff) begin
                    pc_q     <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
                    kill_cnt <= 2'd1;
                end else begin
                    pc_q <= pc_q + PC_WIDTH'(4);
                    if (kill_cnt != 2'd0) begin
                        kill_cnt <= kill_cnt - 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit with randomized stall/flush stimulus
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] current_pc;
    logic [31:0] instruction;
    logic        valid;
    logic        misalign;
    logic [31:0] fetch_cnt;

    pc_fetch_unit #(
        .PC_WIDTH  (32),
        .DATA_WIDTH(32),
        .RESET_PC  (RESET_PC),
        .NOP_INST  (NOP_INST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .redirect_pc_i(redirect_pc),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .current_pc_o (current_pc),
        .instruction_o(instruction),
        .valid_o      (valid),
        .misalign_o   (misalign),
        .fetch_cnt_o  (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Word-indexed memory image: mem[i] = i
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // Synchronous instruction memory, one-cycle read latency
    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    typedef struct {
        bit          skip;
        bit          valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] cnt;
        bit          mis;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, described in terms of the fetch stream
    logic [31:0] m_issue;
    logic [31:0] m_prev;
    bit          m_first;
    bit          m_window;
    bit          m_mis;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, push the expected outputs for it, then advance the model
    task automatic cyc(input bit r, input bit s, input bit f, input logic [31:0] t);
        exp_t e;
        bit   fe;
        @(negedge clk);
        rst = r;
        stall = s;
        flush = f;
        redirect_pc = t;
        e = '{default: '0};
        if (r) begin
            e.skip = 1'b1;
            sb.push_back(e);
            m_issue  = RESET_PC;
            m_prev   = RESET_PC;
            m_first  = 1'b1;
            m_window = 1'b0;
            m_mis    = 1'b0;
            m_cnt    = 32'd0;
            return;
        end
        fe      = f && !s;
        e.valid = !(m_first || fe || m_window);
        e.pc    = m_prev;
        e.inst  = e.valid ? mem_word(m_prev) : NOP_INST;
        e.addr  = m_issue;
        e.cnt   = m_cnt;
        e.mis   = m_mis;
        sb.push_back(e);
        if (e.valid && !s) m_cnt = m_cnt + 32'd1;
        m_prev  = m_issue;
        m_mis   = fe && (t[1:0] != 2'b00);
        m_first = 1'b0;
        if (!s) begin
            if (fe) begin
                m_issue  = {t[31:2], 2'b00};
                m_window = 1'b1;
            end else begin
                m_issue  = m_issue + 32'd4;
                m_window = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Monitor: pops one expected record per cycle and compares away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (!e.skip) begin
                    chk("valid", {31'd0, valid}, {31'd0, e.valid});
                    chk("instruction", instruction, e.inst);
                    chk("imem_addr", imem_addr, e.addr);
                    chk("fetch_cnt", fetch_cnt, e.cnt);
                    chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                    if (e.valid) chk("current_pc", current_pc, e.pc);
                end
            end
        end
    end

    initial begin
        logic [31:0] t;
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        run(4);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        run(3);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        run(4);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        run(2);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        run(3);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        run(4);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0203);
        run(3);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0500);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        run(3);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        run(4);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        run(4);
        for (int i = 0; i < 600; i++) begin
            t = $urandom;
            if ($urandom_range(0, 99) < 20) t[31:12] = 20'hFFFFF;
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
                $urandom_range(0, 99) < 15, t);
        end
        run(3);
        @(negedge clk);
        @(negedge clk);
        #4;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
